imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 11, meaning the instruction-memory word-address width, equal to fetch address bits pc[12:2].
REQ-002 The block SHALL have parameter MAX_WORDS, default 2048, meaning the memory depth in words (2**ADDR_W).
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  meaning reset, asynchronous and active-low.
REQ-005 The block SHALL have port start  input  1  meaning a single-cycle load request.
REQ-006 The block SHALL have port word_count  input  12  meaning the number of words to load, sampled when start is accepted.
REQ-007 The block SHALL have port abort  input  1  meaning cancel the load in progress.
REQ-008 The block SHALL have port byte_in  input  8  meaning the program byte stream.
REQ-009 The block SHALL have port byte_valid  input  1  meaning byte_in is valid.
REQ-010 The block SHALL have port byte_ready  output  1  meaning the block accepts byte_in this cycle.
REQ-011 The block SHALL have port imem_we  output  1  meaning the instruction-memory write strobe.
REQ-012 The block SHALL have port imem_addr  output  ADDR_W  meaning the instruction-memory word address.
REQ-013 The block SHALL have port imem_wdata  output  32  meaning the instruction word to write.
REQ-014 The block SHALL have port cpu_hold  output  1  meaning the fetch stage is disabled and must issue bubbles (drives disable_pc).
REQ-015 The block SHALL have port load_done  output  1  meaning a one-cycle pulse when a load completes.
REQ-016 The block SHALL have port loaded_words  output  12  meaning the number of words written by the current or last load.

Function
REQ-017 The block SHALL implement the states IDLE, COLLECT, WRITE and DONE.
REQ-018 In IDLE, start SHALL be accepted: the block latches min(word_count, MAX_WORDS), clears imem_addr, loaded_words and the byte index, and goes to COLLECT; if the latched count is 0, it SHALL instead pulse load_done next cycle and stay in IDLE.
REQ-019 start SHALL be ignored in every state other than IDLE.
REQ-020 A byte handshake SHALL occur only when byte_valid=1 and byte_ready=1, and byte_ready SHALL be 1 only in COLLECT.
REQ-021 Assembly SHALL be little-endian: accepted byte k (k = 0..3) lands in imem_wdata[8k+7:8k].
REQ-022 After the 4th handshake, the next cycle SHALL be WRITE, with byte_ready=0.
REQ-023 WRITE SHALL last exactly one cycle with imem_we=1 and stable imem_addr/imem_wdata; imem_we SHALL be 0 in every other state.
REQ-024 On leaving WRITE, loaded_words SHALL increment; if it then equals the latched count, the block goes to DONE, otherwise imem_addr increments and the block returns to COLLECT with byte index 0.
REQ-025 imem_addr SHALL never wrap: the clamp guarantees the last write is at MAX_WORDS-1.
REQ-026 DONE SHALL last one cycle with load_done=1, then the block returns to IDLE.
REQ-027 cpu_hold SHALL be 1 in COLLECT, WRITE and DONE, and 0 in IDLE.
REQ-028 The first fetch after release SHALL therefore see a fully written memory.
REQ-029 abort in COLLECT or WRITE SHALL take priority: the block goes to IDLE next cycle, suppresses any write in that cycle, discards a partial word, and does not pulse load_done.
REQ-030 Words already written SHALL remain after an abort, and loaded_words SHALL hold their count.
REQ-031 abort in IDLE or DONE SHALL be ignored.
REQ-032 Byte data presented while byte_ready=0 SHALL not be consumed.

Reset
REQ-033 While rst_n=0, the block SHALL be in IDLE with byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=0, load_done=0, loaded_words=0 and byte index 0.
REQ-034 Reset asserted mid-load SHALL abandon the load immediately (asynchronously), with no further write and no load_done.

Verification
REQ-035 The bench SHALL cover: start with word_count=2, then bytes 13,00,08,20 and 04,00,09,24 -> writes 0x20080013 @0 and 0x24090004 @1, load_done one cycle after the 2nd write, cpu_hold high from the cycle after start through DONE.
REQ-036 The bench SHALL cover: byte_valid toggled 1-0-1 (gaps) during COLLECT -> exactly 4 handshakes per word, wdata unaffected by bytes presented while byte_ready=0.
REQ-037 The bench SHALL cover: word_count=0 -> no write, cpu_hold stays 0, load_done pulses once; and word_count=4095 -> clamped to 2048, final write at address 0x7FF, no wrap.
REQ-038 The bench SHALL cover: abort after 2 bytes of word 3 -> IDLE next cycle, no write at address 3, loaded_words=3, no load_done.
REQ-039 The bench SHALL cover: rst_n dropped during WRITE -> imem_we=0 immediately, all outputs at reset values; a new start after release loads from address 0.
REQ-040 The bench SHALL cover: start pulsed during COLLECT -> ignored, latched count and address unchanged.

Source files
------------

// File: rtl/imem_loader.sv
// Streams a byte program into instruction memory as little-endian 32-bit words while holding the CPU fetch stage.
// Latency: 4 accepted bytes then 1 WRITE cycle per word; load_done 1 cycle after the last write; zero-length load pulses done 1 cycle after start.
// Backpressure: byte_ready is high only while collecting bytes; bytes offered at any other time are left unconsumed.
module imem_loader #(
    parameter int ADDR_W    = 11,
    parameter int MAX_WORDS = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [11:0]       word_count,
    input  logic              abort,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [11:0]       loaded_words
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [11:0] MAX_CNT = 12'(MAX_WORDS);

    state_t      state;
    logic [11:0] count_q;
    logic [1:0]  byte_idx;
    logic [11:0] clamped_count;
    logic [11:0] words_next;

    // Clamping the requested length to the memory depth is what keeps imem_addr from ever wrapping.
    assign clamped_count = (word_count > MAX_CNT) ? MAX_CNT : word_count;
    assign words_next    = loaded_words + 12'd1;

    // Output strobes decode straight from the state register; abort vetoes a write in the same cycle.
    assign byte_ready = (state == COLLECT);
    assign imem_we    = (state == WRITE) && !abort;
    assign cpu_hold   = (state != IDLE);

    // Load sequencer: accept start, gather four bytes, write one word, repeat until the latched count is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            count_q      <= '0;
            byte_idx     <= '0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            loaded_words <= '0;
            load_done    <= 1'b0;
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        count_q      <= clamped_count;
                        imem_addr    <= '0;
                        loaded_words <= '0;
                        byte_idx     <= '0;
                        if (clamped_count == 12'd0) begin
                            load_done <= 1'b1;
                        end else begin
                            state <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (abort) begin
                        // Partial word is dropped; words already written and their count stay.
                        state    <= IDLE;
                        byte_idx <= '0;
                    end else if (byte_valid) begin
                        imem_wdata[{byte_idx, 3'b000} +: 8] <= byte_in;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    byte_idx <= '0;
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        loaded_words <= words_next;
                        if (words_next == count_q) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                        end else begin
                            imem_addr <= imem_addr + ADDR_W'(1);
                            state     <= COLLECT;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte streaming, gaps, clamping, zero length, abort, reset mid-write, stray start.
// Latency: checks sampled 1 time unit after the rising edge; a negedge monitor records writes, handshakes and done pulses.
// Backpressure: byte sends wait on byte_ready with a bounded cycle budget.
module tb_imem_loader;

    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [11:0]       word_count;
    logic              abort;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic [11:0]       loaded_words;

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(2048)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .word_count   (word_count),
        .abort        (abort),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .loaded_words (loaded_words)
    );

    always #5 clk = ~clk;

    int nerr = 0;
    int nchk = 0;
    int wr_cnt = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [31:0]       last_data = '0;
    logic [31:0]       mem [0:2047];

    // Memory model and event counters, sampled mid-cycle so inputs driven after the edge have settled.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_cnt++;
            last_addr = imem_addr;
            last_data = imem_wdata;
            mem[imem_addr] = imem_wdata;
        end
        if (byte_valid && byte_ready) hs_cnt++;
        if (load_done) done_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [11:0] n);
        start      = 1'b1;
        word_count = n;
        tick();
        start      = 1'b0;
        word_count = 12'h0AA;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic ok;
        ok         = 1'b0;
        byte_valid = 1'b1;
        byte_in    = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = byte_ready;
            tick();
        end
        byte_valid = 1'b0;
        byte_in    = 8'hEE;
        if (!ok) begin
            nchk++;
            nerr++;
            $error("FAIL send_byte: observed=no handshake expected=handshake within 20 cycles");
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    initial begin
        int wr0, hs0, dn0;
        logic [7:0] b;
        rst_n = 1'b0; start = 1'b0; word_count = '0; abort = 1'b0;
        byte_in = '0; byte_valid = 1'b0;

        // Reset values
        #12;
        check("rst byte_ready", {31'b0, byte_ready}, 32'd0);
        check("rst imem_we", {31'b0, imem_we}, 32'd0);
        check("rst imem_addr", {21'b0, imem_addr}, 32'd0);
        check("rst imem_wdata", imem_wdata, 32'd0);
        check("rst cpu_hold", {31'b0, cpu_hold}, 32'd0);
        check("rst load_done", {31'b0, load_done}, 32'd0);
        check("rst loaded_words", {20'b0, loaded_words}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Two-word load with the reference program
        check("A hold before start", {31'b0, cpu_hold}, 32'd0);
        pulse_start(12'd2);
        check("A hold after start", {31'b0, cpu_hold}, 32'd1);
        check("A ready in collect", {31'b0, byte_ready}, 32'd1);
        send_word(32'h20080013);
        check("A w0 we", {31'b0, imem_we}, 32'd1);
        check("A w0 ready low", {31'b0, byte_ready}, 32'd0);
        check("A w0 addr", {21'b0, imem_addr}, 32'd0);
        check("A w0 data", imem_wdata, 32'h20080013);
        tick();
        check("A addr inc", {21'b0, imem_addr}, 32'd1);
        check("A loaded 1", {20'b0, loaded_words}, 32'd1);
        check("A we low in collect", {31'b0, imem_we}, 32'd0);
        send_word(32'h24090004);
        check("A w1 we", {31'b0, imem_we}, 32'd1);
        check("A w1 addr", {21'b0, imem_addr}, 32'd1);
        check("A w1 data", imem_wdata, 32'h24090004);
        tick();
        check("A done pulse", {31'b0, load_done}, 32'd1);
        check("A hold in done", {31'b0, cpu_hold}, 32'd1);
        check("A loaded 2", {20'b0, loaded_words}, 32'd2);
        tick();
        check("A done clears", {31'b0, load_done}, 32'd0);
        check("A hold released", {31'b0, cpu_hold}, 32'd0);
        check("A write count", wr_cnt, 32'd2);
        check("A mem0", mem[0], 32'h20080013);

        // Gapped byte_valid; bytes offered while not ready must not be taken
        hs0 = hs_cnt; wr0 = wr_cnt;
        byte_valid = 1'b1; byte_in = 8'h55;
        tick();
        byte_valid = 1'b0;
        check("B idle no handshake", hs_cnt - hs0, 32'd0);
        pulse_start(12'd1);
        send_byte(8'h11); byte_in = 8'h99; tick();
        send_byte(8'h22); byte_in = 8'h99; tick();
        send_byte(8'h33); byte_in = 8'h99; tick();
        send_byte(8'h44);
        byte_valid = 1'b1; byte_in = 8'hFF;
        check("B gap data", imem_wdata, 32'h44332211);
        check("B gap we", {31'b0, imem_we}, 32'd1);
        tick();
        byte_valid = 1'b0;
        check("B handshakes", hs_cnt - hs0, 32'd4);
        check("B writes", wr_cnt - wr0, 32'd1);
        tick();

        // Zero-length load
        wr0 = wr_cnt; dn0 = done_cnt;
        pulse_start(12'd0);
        check("C done pulse", {31'b0, load_done}, 32'd1);
        check("C hold stays low", {31'b0, cpu_hold}, 32'd0);
        check("C no ready", {31'b0, byte_ready}, 32'd0);
        tick();
        check("C done clears", {31'b0, load_done}, 32'd0);
        tick();
        check("C no write", wr_cnt - wr0, 32'd0);
        check("C one done", done_cnt - dn0, 32'd1);

        // Start during COLLECT is ignored
        wr0 = wr_cnt;
        pulse_start(12'd2);
        send_byte(8'hA1); send_byte(8'hB2);
        start = 1'b1; word_count = 12'd1;
        tick();
        start = 1'b0;
        send_byte(8'hC3); send_byte(8'hD4);
        check("F data intact", imem_wdata, 32'hD4C3B2A1);
        check("F addr 0", {21'b0, imem_addr}, 32'd0);
        tick();
        check("F still collecting", {31'b0, byte_ready}, 32'd1);
        check("F addr 1", {21'b0, imem_addr}, 32'd1);
        check("F no done", {31'b0, load_done}, 32'd0);
        abort = 1'b1; tick(); abort = 1'b0;
        check("F aborted idle", {31'b0, cpu_hold}, 32'd0);

        // Abort after two bytes of word 3
        wr0 = wr_cnt; dn0 = done_cnt;
        pulse_start(12'd5);
        send_word(32'h00000000); tick();
        send_word(32'h11111111); tick();
        send_word(32'h22222222); tick();
        send_byte(8'h33); send_byte(8'h33);
        abort = 1'b1;
        #1;
        check("D we low on abort", {31'b0, imem_we}, 32'd0);
        tick();
        abort = 1'b0;
        check("D idle hold", {31'b0, cpu_hold}, 32'd0);
        check("D idle ready", {31'b0, byte_ready}, 32'd0);
        check("D loaded 3", {20'b0, loaded_words}, 32'd3);
        tick(); tick();
        check("D writes 3", wr_cnt - wr0, 32'd3);
        check("D last addr 2", {21'b0, last_addr}, 32'd2);
        check("D no done", done_cnt - dn0, 32'd0);

        // Abort in WRITE suppresses the write
        wr0 = wr_cnt;
        pulse_start(12'd2);
        send_word(32'h0BADF00D);
        abort = 1'b1;
        #1;
        check("W we suppressed", {31'b0, imem_we}, 32'd0);
        tick();
        abort = 1'b0;
        check("W idle", {31'b0, cpu_hold}, 32'd0);
        check("W loaded 0", {20'b0, loaded_words}, 32'd0);
        check("W no write", wr_cnt - wr0, 32'd0);

        // Oversized request clamps to 2048 words, last address 0x7FF
        wr0 = wr_cnt; dn0 = done_cnt;
        pulse_start(12'd4095);
        for (int w = 0; w < 2048; w++) begin
            for (int k = 0; k < 4; k++) begin
                b = 8'(w) + 8'(k * 64);
                send_byte(b);
            end
            tick();
        end
        check("G done pulse", {31'b0, load_done}, 32'd1);
        check("G loaded 2048", {20'b0, loaded_words}, 32'd2048);
        check("G writes 2048", wr_cnt - wr0, 32'd2048);
        check("G last addr", {21'b0, last_addr}, 32'h7FF);
        check("G last data", last_data, 32'hBF7F3FFF);
        check("G mem0 not wrapped", mem[0], 32'hC0804000);
        tick(); tick();
        check("G one done", done_cnt - dn0, 32'd1);
        check("G idle", {31'b0, cpu_hold}, 32'd0);

        // Reset during WRITE, then a fresh load from address 0
        wr0 = wr_cnt; dn0 = done_cnt;
        pulse_start(12'd3);
        send_word(32'h01020304); tick();
        send_word(32'h05060708);
        check("E in write", {31'b0, imem_we}, 32'd1);
        check("E addr 1", {21'b0, imem_addr}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("E we drops", {31'b0, imem_we}, 32'd0);
        check("E hold drops", {31'b0, cpu_hold}, 32'd0);
        check("E addr reset", {21'b0, imem_addr}, 32'd0);
        check("E wdata reset", imem_wdata, 32'd0);
        check("E loaded reset", {20'b0, loaded_words}, 32'd0);
        check("E ready reset", {31'b0, byte_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("E one write only", wr_cnt - wr0, 32'd1);
        check("E no done", done_cnt - dn0, 32'd0);
        pulse_start(12'd1);
        send_word(32'hCAFEF00D);
        check("E reload addr", {21'b0, imem_addr}, 32'd0);
        check("E reload data", imem_wdata, 32'hCAFEF00D);
        tick();
        check("E reload done", {31'b0, load_done}, 32'd1);
        tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
